ip_fuzz_responder: RTL

IP-side agent of the central fuzzing protocol, instantiated next to each fuzzed IP. It accepts trigger writes from the central fuzzer's Wishbone master and answers its trigger-ack polls. It then drives a burst of fuzz vectors into the local IP. On completion it reports a fuzz-ack, or on an IP anomaly an anomaly indication plus payload, by initiating writes toward the central fuzzer's slave port.

---
 rtl/ip_fuzz_responder.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/ip_fuzz_responder.sv
// IP-side fuzz agent: takes trigger writes, streams fuzz vectors into the IP, reports fuzz-ack/anomaly upstream.
// Latency: slave access completes the cycle after s_req is sampled; the first vector is offered the cycle after the trigger.
// Backpressure: vectors hold while fuzz_ready is low; master writes hold until m_done.
module ip_fuzz_responder #(
    parameter int                    ADDR_WIDTH              = 32,
    parameter int                    DATA_WIDTH              = 32,
    parameter logic [ADDR_WIDTH-1:0] TRIG_ADDR               = 32'h3000_0000,
    parameter logic [ADDR_WIDTH-1:0] TRIGGER_ACK_ADDR        = 32'h3000_0004,
    parameter logic [DATA_WIDTH-1:0] TRIGGER_ACK_DATA        = 32'h5A5A_0001,
    parameter logic [ADDR_WIDTH-1:0] FUZZ_ACK_ADDR           = 32'h4000_0000,
    parameter logic [DATA_WIDTH-1:0] FUZZ_ACK_DATA           = 32'h63A9_1243,
    parameter logic [ADDR_WIDTH-1:0] ANOMALY_INDICATION_ADDR = 32'h4000_0004,
    parameter logic [DATA_WIDTH-1:0] ANOMALY_INDICATION_DATA = 32'hDEAD_0001,
    parameter logic [ADDR_WIDTH-1:0] ANOMALY_DATA_ADDR       = 32'h4000_0008,
    parameter int                    NUM_VECTORS             = 16,
    parameter logic [DATA_WIDTH-1:0] LFSR_SEED               = 32'h0000_0001
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_req,
    input  logic                  s_we,
    input  logic [ADDR_WIDTH-1:0] s_addr,
    input  logic [DATA_WIDTH-1:0] s_wdata,
    output logic [DATA_WIDTH-1:0] s_rdata,
    output logic                  s_done,
    output logic                  m_req,
    output logic                  m_we,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0] m_wdata,
    input  logic                  m_done,
    output logic                  fuzz_valid,
    output logic [DATA_WIDTH-1:0] fuzz_data,
    input  logic                  fuzz_ready,
    input  logic                  ip_anomaly,
    output logic                  busy
);

    localparam int                    CW         = $clog2(NUM_VECTORS + 1);
    localparam logic [DATA_WIDTH-1:0] CMD_RANDOM = 32'hA000_0111;
    localparam logic [DATA_WIDTH-1:0] CMD_CORNER = 32'hA000_0222;
    localparam logic [DATA_WIDTH-1:0] LFSR_POLY  = 32'h8020_0003;

    typedef enum logic [2:0] {
        IDLE,
        FUZZ,
        SEND_FACK,
        SEND_AIND,
        SEND_ADATA
    } state_t;

    state_t                state, state_nxt;
    logic                  armed;
    logic                  mode_corner;
    logic [DATA_WIDTH-1:0] lfsr;
    logic [DATA_WIDTH-1:0] last_vec;
    logic [1:0]            corner_idx;
    logic [CW-1:0]         count;
    logic [DATA_WIDTH-1:0] cur_vec;
    logic                  s_acc;
    logic                  trig_hit;
    logic                  hs;
    logic                  m_fin;

    // A request seen in the done cycle is the same transfer still held; don't re-accept it.
    assign s_acc    = s_req && !s_done;
    assign trig_hit = s_acc && s_we && (s_addr == TRIG_ADDR) && (state == IDLE) &&
                      ((s_wdata == CMD_RANDOM) || (s_wdata == CMD_CORNER));
    assign hs       = fuzz_valid && fuzz_ready;
    assign m_fin    = m_req && m_done;

    always_comb begin
        cur_vec = lfsr;
        if (mode_corner) begin
            unique case (corner_idx)
                2'd0:    cur_vec = {DATA_WIDTH{1'b0}};
                2'd1:    cur_vec = {DATA_WIDTH{1'b1}};
                2'd2:    cur_vec = {1'b1, {(DATA_WIDTH-1){1'b0}}};
                default: cur_vec = {1'b0, {(DATA_WIDTH-1){1'b1}}};
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Anomaly outranks count completion, even on the final handshake.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:       if (trig_hit) state_nxt = FUZZ;
            FUZZ: begin
                if (ip_anomaly) begin
                    state_nxt = SEND_AIND;
                end else if (hs && (count == CW'(NUM_VECTORS - 1))) begin
                    state_nxt = SEND_FACK;
                end
            end
            SEND_FACK:  if (m_fin) state_nxt = IDLE;
            SEND_AIND:  if (m_fin) state_nxt = SEND_ADATA;
            SEND_ADATA: if (m_fin) state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    assign fuzz_valid = (state == FUZZ);
    assign fuzz_data  = fuzz_valid ? cur_vec : '0;
    assign busy       = (state != IDLE);
    assign m_we       = m_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_done  <= 1'b0;
            s_rdata <= '0;
        end else begin
            s_done  <= s_acc;
            s_rdata <= (s_acc && !s_we && (s_addr == TRIGGER_ACK_ADDR) && armed) ?
                       TRIGGER_ACK_DATA : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed       <= 1'b0;
            mode_corner <= 1'b0;
            count       <= '0;
            last_vec    <= '0;
            lfsr        <= LFSR_SEED;
            corner_idx  <= 2'd0;
        end else begin
            if (trig_hit) begin
                armed       <= 1'b1;
                mode_corner <= (s_wdata == CMD_CORNER);
                count       <= '0;
                last_vec    <= '0;
            end else if (state != IDLE && state_nxt == IDLE) begin
                armed <= 1'b0;
            end
            if (hs) begin
                last_vec <= cur_vec;
                count    <= count + CW'(1);
                if (mode_corner) begin
                    corner_idx <= corner_idx + 2'd1;
                end else begin
                    lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_POLY : '0);
                end
            end
        end
    end

    // Dropping m_req on completion and re-arming from state_nxt leaves a one-cycle gap between chained sends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_req   <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
        end else if (m_fin) begin
            m_req   <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
        end else if (!m_req) begin
            unique case (state_nxt)
                SEND_FACK: begin
                    m_req   <= 1'b1;
                    m_addr  <= FUZZ_ACK_ADDR;
                    m_wdata <= FUZZ_ACK_DATA;
                end
                SEND_AIND: begin
                    m_req   <= 1'b1;
                    m_addr  <= ANOMALY_INDICATION_ADDR;
                    m_wdata <= ANOMALY_INDICATION_DATA;
                end
                SEND_ADATA: begin
                    m_req   <= 1'b1;
                    m_addr  <= ANOMALY_DATA_ADDR;
                    m_wdata <= last_vec;
                end
                default: begin
                    m_req   <= 1'b0;
                    m_addr  <= '0;
                    m_wdata <= '0;
                end
            endcase
        end
    end

endmodule
